ahb_mst_sif: RTL and testbench
==============================

# ahb_mst_sif

AHB-Lite master bridge converting a single-outstanding valid/hold client request into one 32-bit AHB-Lite transfer. It is the initiator counterpart of the AHB slave interface in front of the crypto cores: firmware-offload engines and DMA-style sequencers use it to write SHA3 message words and read digest/status registers over the fabric. Only one transfer is outstanding at a time; address and data phases are never overlapped.

## Interface
- AHB_ADDR_WIDTH, 32, width of haddr_o and addr_i
- AHB_DATA_WIDTH, 32, width of hwdata_o/hrdata_i; must be 32
- TIMEOUT_CYCLES, 256, data-phase wait-state limit; used only with AHB_MST_TIMEOUT_EN
- clk  in  1  clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- haddr_o  out  AHB_ADDR_WIDTH  transfer address, bits[1:0] forced 0
- htrans_o  out  2  2'b00 IDLE / 2'b10 NONSEQ
- hwrite_o  out  1  1 = write
- hsize_o  out  3  always 3'b010 when NONSEQ, 3'b000 otherwise
- hwdata_o  out  AHB_DATA_WIDTH  write data, valid in data phase
- hready_i  in  1  transfer ready from interconnect
- hresp_i  in  1  1 = ERROR response
- hrdata_i  in  AHB_DATA_WIDTH  read data
- dv_i  in  1  client request valid
- write_i  in  1  client request is write
- addr_i  in  AHB_ADDR_WIDTH  client byte address
- wdata_i  in  32  client write data
- hld_o  out  1  busy; request not accepted while high
- ack_o  out  1  one-cycle completion pulse
- err_o  out  1  with ack_o: transfer ended in error/timeout
- rdata_o  out  32  read data, valid with ack_o on reads

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: hld_o=0, htrans_o=IDLE. Request accepted on cycle with dv_i=1 (hld_o is 0 in IDLE); addr_i/write_i/wdata_i captured; next state ADDR.
- ADDR: htrans_o=NONSEQ, haddr_o/hwrite_o/hsize_o from capture, hld_o=1. hready_i=1 -> DATA; hready_i=0 -> stay, outputs held stable.
- DATA: htrans_o=IDLE, hwdata_o=captured wdata (writes; held at last value on reads), hld_o=1. hready_i=0 -> wait (wait states, including first ERROR cycle). hready_i=1 -> IDLE; ack_o=1 next cycle; err_o=hresp_i sampled; rdata_o=hrdata_i on read with hresp_i=0, else unchanged.
- ack_o coincides with first IDLE cycle; a dv_i in that cycle is accepted (back-to-back).
- dv_i while hld_o=1 is ignored; client holds request until accepted.
- Reset values: htrans_o=0, haddr_o=0, hwrite_o=0, hsize_o=0, hwdata_o=0, hld_o=0, ack_o=0, err_o=0, rdata_o=0, state IDLE.
- Reset mid-transfer: all outputs go to reset values immediately; transfer dropped, no ack_o.

## Timing
- Accept cycle N (dv_i=1, IDLE) -> NONSEQ at N+1 -> data phase N+2 -> ack_o at N+3 with zero wait states; each wait state adds one cycle.
- Min back-to-back throughput: one transfer per 3 cycles.
- ERROR: hresp_i=1/hready_i=0 then hresp_i=1/hready_i=1; completion on second cycle, err_o=1 with ack_o.
- ack_o, err_o single-cycle pulses; rdata_o holds until next read completion.

## Configuration
- AHB_MST_TIMEOUT_EN defined: 16-bit counter clears on DATA entry, increments each DATA cycle with hready_i=0; on reaching TIMEOUT_CYCLES, state -> IDLE, ack_o=1 and err_o=1 next cycle, rdata_o unchanged; late hready_i from the abandoned transfer ignored.
- Undefined: no counter; DATA waits indefinitely for hready_i.

## Test plan
- Zero-wait write addr_i=0x0000_0810, wdata_i=0xA5A5_5A5A -> NONSEQ at N+1 with haddr_o=0x810, hwrite_o=1, hsize_o=3'b010; hwdata_o=0xA5A5_5A5A at N+2; ack_o=1, err_o=0 at N+3.
- Read addr_i=0x0000_0813 with 2 data-phase wait states, hrdata_i=0xDEAD_BEEF -> haddr_o=0x810; hld_o high 4 cycles; ack_o at N+5 with rdata_o=0xDEAD_BEEF.
- Two-cycle ERROR response on write -> ack_o=1, err_o=1; rdata_o keeps previous value; next request accepted same cycle as ack_o.
- Back-to-back: dv_i held high for 3 writes -> NONSEQ at N+1, N+4, N+7; three ack_o pulses, err_o=0.
- rst asserted during DATA of a read -> htrans_o=0, hld_o=0 immediately; no ack_o after release; next read completes normally.
- With AHB_MST_TIMEOUT_EN, TIMEOUT_CYCLES=8, hready_i held 0 in DATA -> ack_o=1, err_o=1 after 8 wait cycles; without macro, hld_o stays 1 for 1000 cycles.

Source files
------------

// File: rtl/ahb_mst_sif.sv
// ahb_mst_sif -- AHB-Lite master bridge, single outstanding 32-bit transfer.
//
// Converts one valid/hold client request into one NONSEQ AHB-Lite transfer.
// Address and data phases are never overlapped, so a new request is taken
// only once the previous data phase has completed.
//
// Optional feature macro: AHB_MST_TIMEOUT_EN
//   defined   : a 16-bit wait-state counter abandons a data phase after
//               TIMEOUT_CYCLES wait cycles and completes it with an error.
//   undefined : the data phase waits indefinitely for hready_i.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   haddr_o   [AW-1:0]    transfer address (word aligned)
//   htrans_o  [1:0]       IDLE (2'b00) / NONSEQ (2'b10)
//   hwrite_o              1 = write
//   hsize_o   [2:0]       3'b010 during NONSEQ, otherwise 3'b000
//   hwdata_o  [DW-1:0]    write data, presented in the data phase
//   hready_i, hresp_i     transfer ready / ERROR response
//   hrdata_i  [DW-1:0]    read data
//   dv_i, write_i         client request valid / request is a write
//   addr_i, wdata_i       client byte address / write data
//   hld_o                 busy; a request is not accepted while high
//   ack_o, err_o          one-cycle completion pulse / completion in error
//   rdata_o   [31:0]      read data, valid with ack_o on a successful read
//
// Client handshake: a request is taken on any rising edge where dv_i=1 and
// hld_o=0; the client keeps dv_i and its fields stable until then, and dv_i
// seen while hld_o=1 is ignored. Each accepted request yields exactly one
// ack_o pulse unless reset intervenes.
module ahb_mst_sif #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic                      hready_i,
    input  logic                      hresp_i,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      dv_i,
    input  logic                      write_i,
    input  logic [AHB_ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]               wdata_i,
    output logic                      hld_o,
    output logic                      ack_o,
    output logic                      err_o,
    output logic [31:0]               rdata_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   done;
    logic   timeout;

    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [AHB_DATA_WIDTH-1:0] wdata_q;

`ifdef AHB_MST_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;

    // Held at zero outside the data phase, so it is clear on DATA entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != ST_DATA) begin
            tmo_cnt <= '0;
        end else if (!hready_i) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (dv_i) begin
                    accept    = 1'b1;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hready_i) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (hready_i) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef AHB_MST_TIMEOUT_EN
                // This is the TIMEOUT_CYCLES-th wait cycle: abandon the transfer.
                else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; write data is only replaced by writes so that
    // hwdata_o keeps its last value across reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= {addr_i[AHB_ADDR_WIDTH-1:2], 2'b00};
            write_q <= write_i;
            if (write_i) begin
                wdata_q <= wdata_i;
            end
        end
    end

    // Completion reporting. rdata_o only moves on an error-free read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o <= done | timeout;
            err_o <= timeout | (done & hresp_i);
            if (done && !write_q && !hresp_i) begin
                rdata_o <= hrdata_i;
            end
        end
    end

    assign haddr_o  = addr_q;
    assign hwrite_o = write_q;
    assign hwdata_o = wdata_q;
    assign htrans_o = (state == ST_ADDR) ? 2'b10 : 2'b00;
    assign hsize_o  = (state == ST_ADDR) ? 3'b010 : 3'b000;
    assign hld_o    = (state != ST_IDLE);

endmodule

// File: tb/tb_ahb_mst_sif.sv
// tb_ahb_mst_sif -- directed bench for ahb_mst_sif.
// Expected address phases and completions are queued when a request is
// accepted; a negedge monitor pops and compares them as the DUT presents
// NONSEQ cycles and ack_o pulses. A reactive slave model answers data
// phases from a queue of per-transfer responses.
// With AHB_MST_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
`timescale 1ns/1ps
module tb_ahb_mst_sif;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AHB_MST_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 256;
`endif
    localparam int K_NORMAL = 0;
    localparam int K_NOACK  = 1;
    localparam int K_TMO    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] haddr_o;
    logic [1:0]    htrans_o;
    logic          hwrite_o;
    logic [2:0]    hsize_o;
    logic [DW-1:0] hwdata_o;
    logic          hready_i;
    logic          hresp_i;
    logic [DW-1:0] hrdata_i;
    logic          dv_i;
    logic          write_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic          hld_o;
    logic          ack_o;
    logic          err_o;
    logic [31:0]   rdata_o;

    ahb_mst_sif #(
        .AHB_ADDR_WIDTH(AW),
        .AHB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .haddr_o  (haddr_o),
        .htrans_o (htrans_o),
        .hwrite_o (hwrite_o),
        .hsize_o  (hsize_o),
        .hwdata_o (hwdata_o),
        .hready_i (hready_i),
        .hresp_i  (hresp_i),
        .hrdata_i (hrdata_i),
        .dv_i     (dv_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .hld_o    (hld_o),
        .ack_o    (ack_o),
        .err_o    (err_o),
        .rdata_o  (rdata_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] ack_q[$];   // {ack cycle, err, rdata}
    logic [96:0] aph_q[$];   // {nonseq cycle, write, wdata, addr}
    logic [64:0] cfg_q[$];   // slave: {wait states, err, hrdata}
    logic [31:0] model_rdata = 32'h0;
    logic        man_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- slave model ----------------
    initial begin : slave
        int   cnt;
        logic in_data;
        logic s_err;
        logic [31:0] s_rd;
        logic [64:0] c;
        cnt = 0; in_data = 1'b0; s_err = 1'b0; s_rd = 32'h0;
        hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'h1111_1111;
        forever begin
            @(posedge clk); #1;
            if (hld_o && htrans_o == 2'b00) begin
                if (man_stall) begin
                    hready_i = 1'b0; hresp_i = 1'b0;
                end else begin
                    if (!in_data) begin
                        in_data = 1'b1;
                        c = (cfg_q.size() != 0) ? cfg_q.pop_front() : 65'h0;
                        cnt = int'(c[64:33]); s_err = c[32]; s_rd = c[31:0];
                    end
                    if (cnt > 0) begin
                        hready_i = 1'b0; hresp_i = s_err && (cnt == 1);
                        hrdata_i = 32'h2222_2222;
                        cnt--;
                    end else begin
                        hready_i = 1'b1; hresp_i = s_err; hrdata_i = s_rd;
                        in_data = 1'b0;
                    end
                end
            end else begin
                hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'h1111_1111;
                in_data = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_ns = 1'b0;
    logic        wchk_pending = 1'b0;
    logic [31:0] wchk_val = 32'h0;

    always @(negedge clk) begin
        logic [96:0] a;
        logic [64:0] k;
        if (rst) begin
            prev_ns = 1'b0;
            wchk_pending = 1'b0;
        end else begin
            if (wchk_pending) begin
                check("hwdata_data_phase", hwdata_o, wchk_val);
                wchk_pending = 1'b0;
            end
            if (htrans_o == 2'b10 && !prev_ns) begin
                if (aph_q.size() == 0) begin
                    check("nonseq_unexpected", 32'(htrans_o), 32'h0);
                end else begin
                    a = aph_q.pop_front();
                    check("nonseq_cycle", 32'(cyc), a[96:65]);
                    check("haddr", haddr_o, a[31:0]);
                    check("hwrite", 32'(hwrite_o), 32'(a[64]));
                    check("hsize", 32'(hsize_o), 32'h2);
                    if (a[64]) begin
                        wchk_pending = 1'b1;
                        wchk_val = a[63:32];
                    end
                end
            end
            prev_ns = (htrans_o == 2'b10);
            if (ack_o) begin
                if (ack_q.size() == 0) begin
                    check("ack_unexpected", 32'(ack_o), 32'h0);
                end else begin
                    k = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), k[64:33]);
                    check("err", 32'(err_o), 32'(k[32]));
                    check("rdata", rdata_o, k[31:0]);
                end
            end else if (err_o) begin
                check("err_without_ack", 32'(err_o), 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input int waits, input logic er, input logic [31:0] hrd,
                         input int kind, output int acc);
        int budget;
        budget = 0;
        dv_i = 1'b1; write_i = wr; addr_i = a; wdata_i = wd;
        do begin
            @(negedge clk);
            budget++;
        end while (hld_o !== 1'b0 && budget < 3000);
        check("accept_hld_low", 32'(hld_o), 32'h0);
        acc = cyc;
        aph_q.push_back({32'(acc + 1), wr, wd, a & 32'hFFFF_FFFC});
        if (kind == K_NORMAL) begin
            if (!wr && !er) model_rdata = hrd;
            ack_q.push_back({32'(acc + 3 + waits), er, model_rdata});
            cfg_q.push_back({32'(waits), er, hrd});
        end else if (kind == K_TMO) begin
            ack_q.push_back({32'(acc + 2 + TMO), 1'b1, model_rdata});
        end
        @(posedge clk); #1;
        dv_i = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((ack_q.size() != 0 || hld_o) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        check("drain_pending_acks", 32'(ack_q.size()), 32'h0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc1, acc2, acc3, cnt;
        rst = 1'b1; dv_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_htrans", 32'(htrans_o), 32'h0);
        check("rst_haddr", haddr_o, 32'h0);
        check("rst_hwrite", 32'(hwrite_o), 32'h0);
        check("rst_hsize", 32'(hsize_o), 32'h0);
        check("rst_hwdata", hwdata_o, 32'h0);
        check("rst_hld", 32'(hld_o), 32'h0);
        check("rst_ack_err", {30'h0, ack_o, err_o}, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write.
        issue(1'b1, 32'h0000_0810, 32'hA5A5_5A5A, 0, 1'b0, 32'h0, K_NORMAL, acc1);
        drain();
        check("idle_hsize", 32'(hsize_o), 32'h0);

        // Unaligned read, two data-phase wait states.
        issue(1'b0, 32'h0000_0813, 32'h0, 2, 1'b0, 32'hDEAD_BEEF, K_NORMAL, acc1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (hld_o) cnt++;
        end
        check("read_hld_cycles", 32'(cnt), 32'h4);
        drain();

        // Two-cycle ERROR on a write, then a read taken in the ack cycle.
        issue(1'b1, 32'h0000_0820, 32'h1234_5678, 1, 1'b1, 32'h0, K_NORMAL, acc1);
        issue(1'b0, 32'h0000_0824, 32'h0, 0, 1'b0, 32'h0BAD_CAFE, K_NORMAL, acc2);
        check("accept_in_ack_cycle", 32'(acc2), 32'(acc1 + 4));
        drain();

        // Back-to-back writes with dv_i held.
        issue(1'b1, 32'h0000_0830, 32'h1111_0001, 0, 1'b0, 32'h0, K_NORMAL, acc1);
        issue(1'b1, 32'h0000_0834, 32'h2222_0002, 0, 1'b0, 32'h0, K_NORMAL, acc2);
        issue(1'b1, 32'h0000_0838, 32'h3333_0003, 0, 1'b0, 32'h0, K_NORMAL, acc3);
        check("b2b_spacing_1", 32'(acc2 - acc1), 32'h3);
        check("b2b_spacing_2", 32'(acc3 - acc2), 32'h3);
        drain();

        // Reset during the data phase of a read.
        man_stall = 1'b1;
        issue(1'b0, 32'h0000_0900, 32'h0, 0, 1'b0, 32'h0, K_NOACK, acc1);
        @(posedge clk); #1;
        check("data_phase_hld", 32'(hld_o), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_htrans", 32'(htrans_o), 32'h0);
        check("midrst_hld", 32'(hld_o), 32'h0);
        check("midrst_haddr", haddr_o, 32'h0);
        model_rdata = 32'h0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        man_stall = 1'b0;
        repeat (5) @(negedge clk);
        check("postrst_rdata", rdata_o, 32'h0);
        @(posedge clk); #1;
        issue(1'b0, 32'h0000_0904, 32'h0, 0, 1'b0, 32'h600D_F00D, K_NORMAL, acc1);
        drain();

`ifdef AHB_MST_TIMEOUT_EN
        // Slave never answers: the transfer is abandoned with an error.
        man_stall = 1'b1;
        issue(1'b0, 32'h0000_0908, 32'h0, 0, 1'b0, 32'h0, K_TMO, acc1);
        drain();
        man_stall = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hld_o) cnt++;
        end
        check("tmo_late_hready_ignored", 32'(cnt), 32'h0);
`else
        // Long stall: the master keeps waiting.
        issue(1'b1, 32'h0000_090C, 32'hCAFE_F00D, 1000, 1'b0, 32'h0, K_NORMAL, acc1);
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (hld_o) cnt++;
        end
        check("stall_hld_1000", 32'(cnt), 32'd1000);
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
